// File: rtl/t_ff_pkg.sv
// t_ff_pkg: mode encodings shared by the T flip-flop counter and its bench
package t_ff_pkg;
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] UP   = 2'b01;
   localparam logic [1:0] DOWN = 2'b10;
   localparam logic [1:0] TGL  = 2'b11;
endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: single T flip-flop with synchronous active-low reset and parallel load
module t_ff_cell (
   input  logic clk,
   input  logic reset,
   input  logic rst_val,
   input  logic load,
   input  logic d,
   input  logic t,
   output logic q
);
   always_ff @(posedge clk)
      if (!reset) q <= rst_val;
      else if (load) q <= d;
      else if (t) q <= ~q;
endmodule

// File: rtl/t_ff_counter.sv
// t_ff_counter: up/down/toggle-mask counter built from per-bit T flip-flops
module t_ff_counter
   import t_ff_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter bit               SATURATE  = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);
   logic [WIDTH-1:0] up_tog, dn_tog, tog;
   logic             all_ones, zero, up, dn, tg;
   // bits that change on +1 / -1 are exactly those whose lower bits are all 1 / all 0
   assign up_tog   = q ^ (q + WIDTH'(1));
   assign dn_tog   = q ^ (q - WIDTH'(1));
   assign all_ones = &q;
   assign zero     = ~|q;
   assign up       = en && mode == UP;
   assign dn       = en && mode == DOWN;
   assign tg       = en && mode == TGL;
   assign tc       = (up && all_ones) || (dn && zero);
   assign tog      = load ? '0
                   : up ? ((SATURATE && all_ones) ? '0 : up_tog)
                   : dn ? ((SATURATE && zero) ? '0 : dn_tog)
                   : tg ? t : '0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell u_cell (
         .clk    (clk),
         .reset  (reset),
         .rst_val(RESET_VAL[i]),
         .load   (load),
         .d      (d[i]),
         .t      (tog[i]),
         .q      (q[i])
      );
   end
   always_ff @(posedge clk)
      if (!reset) wrap <= 1'b0;
      else wrap <= !SATURATE && !load && tc;
endmodule

// File: doc/t_ff_counter.md
T_FF_COUNTER -- requirements
Module: t_ff_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter/register width in bits; legal range 1..32.
REQ-002 Parameter SATURATE, default 0: 0 = counts wrap around; 1 = counts clamp at the limits.
REQ-003 Parameter RESET_VAL, default 0: value loaded into q by reset; WIDTH bits wide.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-006 en  input  1  count/toggle enable.
REQ-007 mode  input  2  operation select: 00 hold, 01 count up, 10 count down, 11 toggle-mask.
REQ-008 load  input  1  synchronous parallel load.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 t  input  WIDTH  per-bit toggle mask, used in mode 11.
REQ-011 q  output  WIDTH  registered counter/register state.
REQ-012 tc  output  1  combinational terminal-count flag.
REQ-013 wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-014 Each rising edge applies exactly one action, in priority order: reset low > load > (en and mode) > hold.
REQ-015 load=1 (reset high): q <= d and wrap <= 0, regardless of en and mode.
REQ-016 en=0 or mode=00: q holds its value and wrap <= 0.
REQ-017 mode=01, en=1: q <= q+1 modulo 2^WIDTH; the next state is formed as T-style toggles (bit i toggles when all lower bits are 1).
REQ-018 mode=10, en=1: q <= q-1 modulo 2^WIDTH (bit i toggles when all lower bits are 0).
REQ-019 mode=11, en=1: q <= q XOR t; wrap <= 0.
REQ-020 SATURATE=1: up count at all-ones holds at all-ones; down count at zero holds at zero; wrap stays 0 permanently.
REQ-021 SATURATE=0: the cycle after an up count from all-ones to 0, or a down count from 0 to all-ones, wrap=1 for exactly one cycle; otherwise wrap=0.
REQ-022 tc = en AND ((mode=01 AND q=all-ones) OR (mode=10 AND q=0)).
REQ-023 tc is independent of load and SATURATE.
REQ-024 Latency: q and wrap update on the same edge that samples the controls; tc follows q, en and mode combinationally with zero latency.
REQ-025 Mode changes take effect on the first edge at which the new mode is sampled; no internal state other than q and wrap exists.
REQ-026 WIDTH=1 SHALL behave as a single T flip-flop: in mode 01 or 10 it toggles each enabled cycle, and in mode 11 it toggles when t[0]=1.

Reset
REQ-027 When reset=0 at a rising edge: q <= RESET_VAL and wrap <= 0.
REQ-028 Reset overrides load, en and mode in the same cycle.
REQ-029 Reset asserted in the middle of a count sequence discards the sequence and forces no wrap pulse.
REQ-030 Between power-up and the first reset edge, q is undefined; the bench does not check q before reset.

Structure
REQ-031 Mode encodings (HOLD, UP, DOWN, TGL) are localparams in the shared package t_ff_pkg, imported by the RTL and the bench.
REQ-032 One sub-module, t_ff_cell, is instantiated WIDTH times: a single T flip-flop with clk, synchronous active-low reset, reset value, load, d, and toggle input.
REQ-033 The top level computes only the per-bit toggle vector, the load/saturate gating, and the tc/wrap logic.
REQ-034 No latches, no clock gating, and no asynchronous logic.

Verification (WIDTH=4, SATURATE=0, RESET_VAL=0 unless stated)
REQ-035 Reset: hold reset=0 for 2 cycles with load=1, d=4'hA -> q=0, wrap=0; release reset, en=1, mode=01 -> q=1, 2, 3 on successive edges.
REQ-036 Up-count wrap: load d=4'hE, then mode=01, en=1 -> q=F with tc=1, then q=0 with wrap=1 for one cycle, then q=1 with wrap=0.
REQ-037 Down-count wrap and saturate: load 1, mode=10 -> q=0 with tc=1, then q=F with wrap=1; with SATURATE=1 the same stimulus holds q=0 and wrap stays 0.
REQ-038 Toggle-mask: q=4'h5, mode=11, t=4'hF -> q=A; then t=4'h1 -> q=B; then en=0 -> q holds at B.
REQ-039 Priority and mid-operation reset: with load=1, d=7, en=1, mode=01, q becomes 7; while counting past q=F, assert reset=0 on the wrap edge -> q=0, wrap=0.
REQ-040 WIDTH=1 instance: mode=01, en=1 -> q toggles 0,1,0,1 with wrap=1 after each 1->0 transition; this matches the legacy single-T-flip-flop sequence.
